// File: rtl/psm_deadtime_nch_if.sv
// Gate-driver control/status bundle for psm_deadtime_nch.
// master: modulator/controller side (drives commands, dead times, limits, fault controls).
// slave : the dead-time block (drives gate outputs, limiter and fault status).
interface psm_deadtime_nch_if #(
    parameter int N_CH    = 3,
    parameter int DT_W    = 8,
    parameter int MAXON_W = 16
);
    logic                i_en;
    logic                i_fault;
    logic                i_fault_clr;
    logic [DT_W-1:0]     i_dt_rise;
    logic [DT_W-1:0]     i_dt_fall;
    logic [MAXON_W-1:0]  i_max_on;
    logic [N_CH-1:0]     i_psm;
    logic [N_CH-1:0]     o_hi;
    logic [N_CH-1:0]     o_lo;
    logic [N_CH-1:0]     o_limit;
    logic                o_fault;

    modport master (
        output i_en, i_fault, i_fault_clr, i_dt_rise, i_dt_fall, i_max_on, i_psm,
        input  o_hi, o_lo, o_limit, o_fault
    );

    modport slave (
        input  i_en, i_fault, i_fault_clr, i_dt_rise, i_dt_fall, i_max_on, i_psm,
        output o_hi, o_lo, o_limit, o_fault
    );
endinterface

// File: rtl/psm_deadtime_nch.sv
// Purpose: N-leg complementary gate driver with rise/fall dead time, max on-time limiter, latched fault.
// Latency: i_psm edge -> active switch off 2 edges later; opposite switch on De cycles after that.
// Backpressure: none; free-running, every input sampled each clk.
// Ports: clk, n_rst (sync, active-low); bus (slave): i_en, i_fault, i_fault_clr, i_dt_rise,
//        i_dt_fall, i_max_on, i_psm in; o_hi, o_lo, o_limit, o_fault out (all from registers).
module psm_deadtime_nch #(
    parameter int N_CH    = 3,
    parameter int DT_W    = 8,
    parameter int DT_MIN  = 2,
    parameter int MAXON_W = 16
) (
    input  logic               clk,
    input  logic               n_rst,
    psm_deadtime_nch_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DT_HI = 3'd1,
        S_HI    = 3'd2,
        S_DT_LO = 3'd3,
        S_LO    = 3'd4
    } state_t;

    localparam logic [DT_W-1:0] DT_MIN_V = DT_W'(DT_MIN);

    state_t              state_q [N_CH];
    state_t              state_d [N_CH];
    logic [DT_W-1:0]     cnt_q   [N_CH];
    logic [DT_W-1:0]     cnt_d   [N_CH];
    logic [DT_W-1:0]     de_q    [N_CH];   // dead time captured on entry to the dead state
    logic [DT_W-1:0]     de_d    [N_CH];
    logic [MAXON_W-1:0]  on_q    [N_CH];
    logic [MAXON_W-1:0]  on_d    [N_CH];
    logic [N_CH-1:0]     lim_q;
    logic [N_CH-1:0]     lim_d;
    logic [N_CH-1:0]     cmd_q;
    logic                fault_q;
    logic                fault_d;
    logic                hold;
    logic [DT_W-1:0]     de_rise;
    logic [DT_W-1:0]     de_fall;
    logic                max_on_en;
    logic [N_CH-1:0]     hi_v;
    logic [N_CH-1:0]     lo_v;

    logic [DT_W:0]       cnt_inc [N_CH];
    logic [N_CH-1:0]     dt_done;
    logic [MAXON_W:0]    on_inc  [N_CH];
    logic [MAXON_W-1:0]  on_sat  [N_CH];
    logic [N_CH-1:0]     on_hit;

    assign de_rise   = (bus.i_dt_rise < DT_MIN_V) ? DT_MIN_V : bus.i_dt_rise;
    assign de_fall   = (bus.i_dt_fall < DT_MIN_V) ? DT_MIN_V : bus.i_dt_fall;
    assign max_on_en = |bus.i_max_on;

    // A fault being sampled this edge already forces IDLE, so outputs drop one cycle after i_fault.
    assign hold    = ~bus.i_en | fault_q | bus.i_fault;
    assign fault_d = bus.i_fault | (fault_q & ~bus.i_fault_clr);

    // Counters are compared one bit wider so count+1 can never wrap.
    for (genvar g = 0; g < N_CH; g++) begin : g_leg
        assign cnt_inc[g] = {1'b0, cnt_q[g]} + (DT_W+1)'(1);
        assign dt_done[g] = cnt_inc[g] >= {1'b0, de_q[g]};
        assign on_inc[g]  = {1'b0, on_q[g]} + (MAXON_W+1)'(1);
        assign on_sat[g]  = on_inc[g][MAXON_W] ? '1 : on_inc[g][MAXON_W-1:0];
        assign on_hit[g]  = on_inc[g] >= {1'b0, bus.i_max_on};
    end

    always_comb begin
        lim_d = lim_q;
        hi_v  = '0;
        lo_v  = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            de_d[i]    = de_q[i];
            on_d[i]    = on_q[i];

            unique case (state_q[i])
                S_IDLE: begin
                    cnt_d[i] = '0;
                    on_d[i]  = '0;
                    lim_d[i] = 1'b0;
                    if (cmd_q[i]) begin
                        state_d[i] = S_DT_HI;
                        de_d[i]    = de_rise;
                    end else begin
                        state_d[i] = S_DT_LO;
                        de_d[i]    = de_fall;
                    end
                end
                S_DT_HI: begin
                    // Command reversal restarts the interval toward the other switch.
                    if (!cmd_q[i]) begin
                        state_d[i] = S_DT_LO;
                        cnt_d[i]   = '0;
                        de_d[i]    = de_fall;
                    end else if (dt_done[i]) begin
                        state_d[i] = S_HI;
                        cnt_d[i]   = '0;
                        on_d[i]    = '0;
                        lim_d[i]   = 1'b0;
                    end else begin
                        cnt_d[i] = cnt_inc[i][DT_W-1:0];
                    end
                end
                S_DT_LO: begin
                    if (cmd_q[i]) begin
                        state_d[i] = S_DT_HI;
                        cnt_d[i]   = '0;
                        de_d[i]    = de_rise;
                    end else if (dt_done[i]) begin
                        state_d[i] = S_LO;
                        cnt_d[i]   = '0;
                        on_d[i]    = '0;
                        lim_d[i]   = 1'b0;
                    end else begin
                        cnt_d[i] = cnt_inc[i][DT_W-1:0];
                    end
                end
                S_HI: begin
                    if (!cmd_q[i]) begin
                        state_d[i] = S_DT_LO;
                        cnt_d[i]   = '0;
                        de_d[i]    = de_fall;
                        on_d[i]    = '0;
                        lim_d[i]   = 1'b0;
                    end else begin
                        on_d[i] = on_sat[i];
                        // Once limited, stay off until the command flips.
                        if (max_on_en && on_hit[i]) lim_d[i] = 1'b1;
                    end
                end
                S_LO: begin
                    if (cmd_q[i]) begin
                        state_d[i] = S_DT_HI;
                        cnt_d[i]   = '0;
                        de_d[i]    = de_rise;
                        on_d[i]    = '0;
                        lim_d[i]   = 1'b0;
                    end else begin
                        on_d[i] = on_sat[i];
                        if (max_on_en && on_hit[i]) lim_d[i] = 1'b1;
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase

            if (hold) begin
                state_d[i] = S_IDLE;
                cnt_d[i]   = '0;
                de_d[i]    = '0;
                on_d[i]    = '0;
                lim_d[i]   = 1'b0;
            end

            hi_v[i] = (state_q[i] == S_HI) && !lim_q[i];
            lo_v[i] = (state_q[i] == S_LO) && !lim_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cmd_q   <= '0;
            fault_q <= 1'b0;
            lim_q   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
                de_q[i]    <= '0;
                on_q[i]    <= '0;
            end
        end else begin
            cmd_q   <= bus.i_psm;
            fault_q <= fault_d;
            lim_q   <= lim_d;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                de_q[i]    <= de_d[i];
                on_q[i]    <= on_d[i];
            end
        end
    end

    assign bus.o_hi    = hi_v;
    assign bus.o_lo    = lo_v;
    assign bus.o_limit = lim_q;
    assign bus.o_fault = fault_q;
endmodule

// File: tb/tb_psm_deadtime_nch.sv
// Bench for psm_deadtime_nch: directed stimulus pushes hand-computed output transitions
// (edge number + full output snapshot) into a queue; the monitor pops one entry for every
// observed change of the outputs and compares cycle and values.
module tb_psm_deadtime_nch;
    localparam int N_CH    = 3;
    localparam int DT_W    = 8;
    localparam int MAXON_W = 16;

    logic clk = 1'b0;
    logic n_rst;
    int   cyc = 0;

    psm_deadtime_nch_if #(.N_CH(N_CH), .DT_W(DT_W), .MAXON_W(MAXON_W)) bus ();

    psm_deadtime_nch #(.N_CH(N_CH), .DT_W(DT_W), .DT_MIN(2), .MAXON_W(MAXON_W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       cyc;
        logic [2:0] hi;
        logic [2:0] lo;
        logic [2:0] lim;
        logic       flt;
    } exp_t;

    exp_t exp_q[$];
    logic mon_on = 1'b0;
    logic done   = 1'b0;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    task automatic expect_ev(input int c, input logic [2:0] hi, input logic [2:0] lo,
                             input logic [2:0] lim, input logic flt);
        exp_t e;
        e.cyc = c; e.hi = hi; e.lo = lo; e.lim = lim; e.flt = flt;
        exp_q.push_back(e);
    endtask

    // Returns 1 ns after posedge number c.
    task automatic at_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor / scoreboard
    initial begin
        logic [9:0] prev;
        logic [9:0] snap;
        exp_t       e;
        int         ovl;
        int         pops;
        ovl  = 0;
        pops = 0;
        wait (mon_on);
        @(negedge clk);
        snap = {bus.o_hi, bus.o_lo, bus.o_limit, bus.o_fault};
        chk_cnt++;
        if (snap === 10'b0) pass_cnt++;
        else $display("FAIL reset_state: got %b, required 0000000000", snap);
        prev = snap;
        while (!done) begin
            @(negedge clk);
            snap = {bus.o_hi, bus.o_lo, bus.o_limit, bus.o_fault};
            if ((bus.o_hi & bus.o_lo) != 3'b000) ovl++;
            if (snap !== prev) begin
                chk_cnt++;
                pops++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_change_%0d: cyc=%0d hi=%b lo=%b lim=%b flt=%b, required no change",
                             pops, cyc, bus.o_hi, bus.o_lo, bus.o_limit, bus.o_fault);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc == cyc && snap == {e.hi, e.lo, e.lim, e.flt}) pass_cnt++;
                    else $display("FAIL ev%0d: got cyc=%0d hi=%b lo=%b lim=%b flt=%b, required cyc=%0d hi=%b lo=%b lim=%b flt=%b",
                                  pops, cyc, bus.o_hi, bus.o_lo, bus.o_limit, bus.o_fault,
                                  e.cyc, e.hi, e.lo, e.lim, e.flt);
                end
                prev = snap;
            end
        end
        chk_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("FAIL missing_events: %0d pending (next due cyc %0d), required 0",
                      exp_q.size(), exp_q[0].cyc);
        chk_cnt++;
        if (ovl == 0) pass_cnt++;
        else $display("FAIL hi_lo_overlap: %0d cycles with o_hi&o_lo, required 0", ovl);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // Stimulus
    initial begin
        n_rst           = 1'b0;
        bus.i_en        = 1'b0;
        bus.i_fault     = 1'b0;
        bus.i_fault_clr = 1'b0;
        bus.i_dt_rise   = 8'd0;
        bus.i_dt_fall   = 8'd0;
        bus.i_max_on    = 16'd0;
        bus.i_psm       = 3'b000;

        // Release reset and enable: all legs IDLE -> DT_LO (De_f=3) -> LO.
        at_cyc(3);
        mon_on        = 1'b1;
        n_rst         = 1'b1;
        bus.i_en      = 1'b1;
        bus.i_dt_rise = 8'd5;
        bus.i_dt_fall = 8'd3;
        expect_ev(7, 3'b000, 3'b111, 3'b000, 1'b0);

        // Leg 0 rise/fall with dt_rise=5, dt_fall=3.
        at_cyc(13);
        bus.i_psm = 3'b001;
        expect_ev(15, 3'b000, 3'b110, 3'b000, 1'b0);
        expect_ev(20, 3'b001, 3'b110, 3'b000, 1'b0);
        at_cyc(33);
        bus.i_psm = 3'b000;
        expect_ev(35, 3'b000, 3'b110, 3'b000, 1'b0);
        expect_ev(38, 3'b000, 3'b111, 3'b000, 1'b0);

        // Dead times below DT_MIN are clamped to 2.
        at_cyc(53);
        bus.i_dt_rise = 8'd0;
        bus.i_dt_fall = 8'd1;
        bus.i_psm     = 3'b001;
        expect_ev(55, 3'b000, 3'b110, 3'b000, 1'b0);
        expect_ev(57, 3'b001, 3'b110, 3'b000, 1'b0);
        at_cyc(63);
        bus.i_psm = 3'b000;
        expect_ev(65, 3'b000, 3'b110, 3'b000, 1'b0);
        expect_ev(67, 3'b000, 3'b111, 3'b000, 1'b0);

        // Max on-time 10 on all legs, high side then low side.
        at_cyc(73);
        bus.i_dt_rise = 8'd4;
        bus.i_dt_fall = 8'd3;
        bus.i_psm     = 3'b111;
        at_cyc(74);
        bus.i_max_on  = 16'd10;
        expect_ev(75,  3'b000, 3'b000, 3'b000, 1'b0);
        expect_ev(79,  3'b111, 3'b000, 3'b000, 1'b0);
        expect_ev(89,  3'b000, 3'b000, 3'b111, 1'b0);
        at_cyc(103);
        bus.i_psm = 3'b000;
        expect_ev(105, 3'b000, 3'b000, 3'b000, 1'b0);
        expect_ev(108, 3'b000, 3'b111, 3'b000, 1'b0);
        expect_ev(118, 3'b000, 3'b000, 3'b111, 1'b0);
        // Clearing max_on does not release a limited leg; a one-cycle disable does.
        at_cyc(123);
        bus.i_max_on = 16'd0;
        at_cyc(128);
        bus.i_en = 1'b0;
        at_cyc(129);
        bus.i_en = 1'b1;
        expect_ev(129, 3'b000, 3'b000, 3'b000, 1'b0);
        expect_ev(133, 3'b000, 3'b111, 3'b000, 1'b0);

        // Short 2-cycle pulse on leg 2 with dt_rise=8: high side never turns on.
        at_cyc(140);
        bus.i_dt_rise = 8'd8;
        bus.i_psm     = 3'b100;
        at_cyc(142);
        bus.i_psm     = 3'b000;
        expect_ev(142, 3'b000, 3'b011, 3'b000, 1'b0);
        expect_ev(147, 3'b000, 3'b111, 3'b000, 1'b0);

        // Fault: legs 0,1 high, then 1-cycle fault, fault+clr, clr alone.
        at_cyc(150);
        bus.i_dt_rise = 8'd5;
        bus.i_psm     = 3'b011;
        expect_ev(152, 3'b000, 3'b100, 3'b000, 1'b0);
        expect_ev(157, 3'b011, 3'b100, 3'b000, 1'b0);
        at_cyc(160);
        bus.i_fault = 1'b1;
        at_cyc(161);
        bus.i_fault = 1'b0;
        expect_ev(161, 3'b000, 3'b000, 3'b000, 1'b1);
        at_cyc(165);
        bus.i_fault     = 1'b1;
        bus.i_fault_clr = 1'b1;
        at_cyc(166);
        bus.i_fault     = 1'b0;
        bus.i_fault_clr = 1'b0;
        at_cyc(170);
        bus.i_fault_clr = 1'b1;
        at_cyc(171);
        bus.i_fault_clr = 1'b0;
        expect_ev(171, 3'b000, 3'b000, 3'b000, 1'b0);
        expect_ev(175, 3'b000, 3'b100, 3'b000, 1'b0);
        expect_ev(177, 3'b011, 3'b100, 3'b000, 1'b0);

        // Reset pulse while legs 0,1 are in HI; cmd_q restarts at 0 so legs abort DT_LO -> DT_HI.
        at_cyc(180);
        n_rst = 1'b0;
        at_cyc(181);
        n_rst = 1'b1;
        expect_ev(181, 3'b000, 3'b000, 3'b000, 1'b0);
        expect_ev(185, 3'b000, 3'b100, 3'b000, 1'b0);
        expect_ev(188, 3'b011, 3'b100, 3'b000, 1'b0);

        // Disable while leg 2 is in DT_HI; re-enable applies full De_r to every leg.
        at_cyc(195);
        bus.i_psm = 3'b111;
        expect_ev(197, 3'b011, 3'b000, 3'b000, 1'b0);
        at_cyc(199);
        bus.i_en = 1'b0;
        at_cyc(200);
        bus.i_en = 1'b1;
        expect_ev(200, 3'b000, 3'b000, 3'b000, 1'b0);
        expect_ev(206, 3'b111, 3'b000, 3'b000, 1'b0);

        at_cyc(215);
        done = 1'b1;
    end
endmodule
